// File: rtl/mnist_pkg.sv
// Canvas geometry, pixel type and reader FSM encoding shared by the MNIST front end.
package mnist_pkg;

   localparam int CANVAS_DIM    = 28;
   localparam int CANVAS_PIXELS = CANVAS_DIM * CANVAS_DIM;
   localparam int CANVAS_ADDR_W = 10;

   typedef logic [7:0] pix8_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } reader_state_e;

endpackage

// File: rtl/canvas_skid_fifo.sv
// Purpose: 2-entry FIFO, valid/ready on both sides, synchronous flush clears contents.
// Latency: one cycle from write to read side; no write-to-read bypass.
// Backpressure: wr_rdy drops when both entries are held; rd_vld never depends on rd_rdy.
module canvas_skid_fifo #(
   parameter int W = 9
) (
   input  logic         Clk,
   input  logic         flush,
   input  logic         wr_vld,
   output logic         wr_rdy,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push;
   logic         pop;

   assign wr_rdy = (count != 2'd2);
   assign rd_vld = (count != 2'd0);
   assign rd_dat = mem[rd_ptr];
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_vld && rd_rdy;

   always_ff @(posedge Clk) begin
      if (flush) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/canvas_reader.sv
// Purpose: scan the canvas RAM row-major and stream 8-bit pixels; CANVAS_READER_CLAMP_EN selects saturation.
// Latency: first beat valid 3 cycles after Start, then 1 beat/cycle with pix_ready high.
// Backpressure: reads issue only when the 2-entry skid buffer has room for them plus any read in flight.
module canvas_reader
   import mnist_pkg::*;
#(
   parameter int DIM   = 28,
   parameter int PIX_W = 16,
   parameter int SHIFT = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   output logic                     Busy,
   output logic                     Done,
   output logic [CANVAS_ADDR_W-1:0] ram_addr,
   output logic                     ram_rd,
   input  logic [PIX_W-1:0]         ram_data,
   output logic [7:0]               pix_data,
   output logic                     pix_valid,
   output logic                     pix_last,
   input  logic                     pix_ready
);

   localparam logic [CANVAS_ADDR_W-1:0] LAST_IDX = CANVAS_ADDR_W'(DIM * DIM - 1);

   reader_state_e            state;
   logic [CANVAS_ADDR_W-1:0] idx;
   logic                     rd_pend;
   logic                     rd_pend_last;
   logic [1:0]               fifo_cnt;
   logic [2:0]               occ;
   logic                     pop;
   logic                     fifo_wr_rdy;
   pix8_t                    pix_conv;

`ifdef CANVAS_READER_CLAMP_EN
   assign pix_conv = ((ram_data >> SHIFT) > PIX_W'(255)) ? 8'hFF : pix8_t'(ram_data >> SHIFT);
`else
   assign pix_conv = pix8_t'(ram_data >> SHIFT);
`endif

   // A beat leaving this cycle frees a slot before the new read's data can land.
   assign pop      = pix_valid && pix_ready;
   assign occ      = {1'b0, fifo_cnt} + {2'b00, rd_pend};
   assign ram_rd   = (state == SCAN) && ((occ < 3'd2) || (pop && occ == 3'd2));
   assign ram_addr = idx;
   assign Busy     = (state != IDLE);
   assign Done     = (state == DRAIN) && pop && pix_last;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         idx          <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
      end else begin
         rd_pend      <= ram_rd;
         rd_pend_last <= ram_rd && (idx == LAST_IDX);
         case (state)
            IDLE: if (Start) state <= SCAN;
            SCAN: begin
               if (ram_rd) begin
                  if (idx == LAST_IDX) begin
                     state <= DRAIN;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DRAIN:   if (Done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   canvas_skid_fifo #(.W(9)) u_fifo (
      .Clk    (Clk),
      .flush  (Reset),
      .wr_vld (rd_pend && fifo_wr_rdy),
      .wr_rdy (fifo_wr_rdy),
      .wr_dat ({rd_pend_last, pix_conv}),
      .rd_vld (pix_valid),
      .rd_rdy (pix_ready),
      .rd_dat ({pix_last, pix_data}),
      .count  (fifo_cnt)
   );

endmodule
